elbeth_fetch_unit: RTL
======================

# elbeth_fetch_unit

Instruction-fetch stage of the ELBETH core. Owns the PC and drives the instruction-memory request handshake. Fills the IF/ID register and accepts redirects from the ID-stage branch unit (`pc_branch`/`branch_taken`) and from the trap logic. Sits between instruction memory and ID; it is the consumer of the branch unit's redirect outputs.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: core clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_branch` in 32: branch/jump target from the ID branch unit.
- `branch_taken` in 1: branch unit's redirect request.
- `trap_valid` in 1: trap/exception redirect request.
- `trap_pc` in 32: trap handler address.
- `id_stall` in 1: ID cannot advance; hold IF/ID.
- `imem_valid` out 1: request outstanding.
- `imem_addr` out 32: fetch address; stable while `imem_valid & ~imem_ready`.
- `imem_ready` in 1: response-complete strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `id_instruction` out 32: IF/ID instruction.
- `id_pc` out 32: IF/ID PC.
- `id_valid` out 1: IF/ID holds a live instruction.
- `fetch_misaligned` out 1: one-cycle pulse on a misaligned branch target.
- `xcpt_addr` out 32: offending target, held until the next pulse.

## Operation
- **States:** REQ (`imem_valid=1`), IDLE (no request), HALT (no request; waiting for trap).
- **Redirect qualifiers:**
  - `br = branch_taken & id_valid & ~id_stall`.
  - `tr = trap_valid`. `tr` has priority over `br`.
- **Branch redirect** (`br & ~tr`):
  - PC is loaded with `pc_branch`.
  - `id_valid<=0`.
  - The skid buffer is cleared.
  - A response accepted in the same cycle is discarded.
  - If REQ is pending with no `imem_ready`, `kill` is set. The next response is discarded and `kill` clears. Address changes only after that response.
- **Trap redirect** (`tr`): same as the branch redirect, with PC loaded from `trap_pc`. It leaves HALT and is valid from any state.
- **Misaligned target** (`br` with `pc_branch[1:0]!=0`):
  - `fetch_misaligned` pulses one cycle and `xcpt_addr` is set to `pc_branch`.
  - `id_valid<=0`; the state goes to HALT once any in-flight request completes (discarded).
  - HALT exits only on `tr`. `trap_pc[1:0]` is ignored (forced to 00).
- **Response routing** (REQ & `imem_ready` & ~kill & no redirect):
  - If `~id_valid | ~id_stall`: IF/ID is loaded with {`rdata`, pc}, `id_valid<=1`.
  - Otherwise the response goes to the one-entry skid buffer.
  - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- **Next state:**
  - REQ if the skid buffer will be empty and ID is not stalled-full.
  - Otherwise IDLE.
- **No new request:** `imem_valid` stays 0 while `id_valid & id_stall`, or while the skid buffer is full.
- **Advance without stall:** when ID advances (`~id_stall`) and nothing is loaded, `id_valid<=0`.
- **Skid drain:** when ID frees, the skid buffer moves to IF/ID. IDLE→REQ happens on the following cycle.
- **Reset values:**
  - pc=`RESET_PC`, state REQ on the first cycle after `rst` deasserts.
  - During `rst`: `imem_valid`=0, `id_valid`=0, `id_instruction`=0, `id_pc`=0, `fetch_misaligned`=0, `xcpt_addr`=0, skid empty, kill=0.
- **Reset mid-request:** the outstanding request is abandoned. The memory must tolerate `imem_valid` dropping under reset.

## Timing
- Accept in cycle N → `id_valid`/`id_instruction`/`id_pc` visible in N+1.
- Zero-wait memory gives one fetch per cycle. `imem_addr` advances by +4 in N+1.
- Redirect in cycle N with no request pending → `imem_addr=target` in N+1. The first target instruction appears in IF/ID at (accept+1).
- Redirect while waiting: the target is issued the cycle after the killed response's `imem_ready`.
- `imem_valid` and `imem_addr` are registered state: no combinational path from `imem_ready` or the redirect inputs.

## Structure
- State encodings `FETCH_REQ`/`FETCH_IDLE`/`FETCH_HALT` and `RESET_PC` default go in `elbeth_definitions.v`.
- The one-entry skid buffer (data, pc, valid; load/drain/flush) is a sub-module, `elbeth_fetch_skid`.
- Everything else lives in `elbeth_fetch_unit`.

## Test plan
- **Reset and streaming:** `rst` high for 2 cycles, `imem_ready`=1 constant, `imem_rdata`=addr^0xA5 → `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles; `id_pc` 0x0, 0x4 one cycle later; no bubbles.
- **Kill during wait:** request 0x8 waits 3 cycles, `br` to 0x100 in wait cycle 1 → `imem_addr` stays 0x8 until `imem_ready`; 0x8's data never reaches IF/ID; next `imem_addr`=0x100; `id_valid`=0 until 0x100 returns.
- **Stall with in-flight response:** `id_valid`=1, `id_stall`=1, response 0x10 arrives → skid holds it, `imem_valid`=0. Stall released → `id_pc`=0x10 next cycle; request 0x14 the cycle after.
- **Misaligned target:** `br` with `pc_branch`=0x102 → `fetch_misaligned`=1 for one cycle, `xcpt_addr`=0x102, `imem_valid`=0. `tr` with `trap_pc`=0x80 → `imem_addr`=0x80 next cycle.
- **Simultaneous redirects:** `br` (0x200) and `tr` (0x80) in the same cycle → next address 0x80. PC wrap: pc=0xFFFF_FFFC accepted → next address 0x0.
- **Reset mid-request:** `rst` pulsed while REQ waits → `imem_valid`=0 during `rst`; `imem_addr`=`RESET_PC` the cycle after; the stale response is not loaded.

Source files
------------

// File: rtl/elbeth_fetch_unit_pkg.sv
// Shared encodings and constants for the ELBETH instruction-fetch stage.
package elbeth_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_IDLE = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_STEP     = 32'd4;

    // A fetch target must be word aligned; only the two LSBs matter.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/elbeth_fetch_skid.sv
// One-entry skid buffer catching a fetch response that arrives while ID is stalled-full.
module elbeth_fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);

    // Flush wins over load so a redirect always leaves the buffer empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= 32'h0;
            pc    <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/elbeth_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake, fills IF/ID.
//
// state      | meaning
// FETCH_REQ  | request outstanding on imem (imem_valid=1)
// FETCH_IDLE | no request; waiting for IF/ID or the skid buffer to free up
// FETCH_HALT | misaligned target taken; no request until a trap redirect
module elbeth_fetch_unit
    import elbeth_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_branch,
    input  logic        branch_taken,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic        id_stall,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        fetch_misaligned,
    output logic [31:0] xcpt_addr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         kill_q, kill_d;
    logic         halt_pend_q, halt_pend_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic         misaligned_q, misaligned_d;
    logic [31:0]  xcpt_q, xcpt_d;

    logic         skid_load, skid_drain, skid_flush;
    logic         skid_valid;
    logic [31:0]  skid_data, skid_pc;

    logic         br, tr, misalign;
    logic         accept, waiting, stalled_full;
    logic [31:0]  redirect_pc;
    logic         unused_trap_lsb;

    assign br           = branch_taken & id_valid_q & ~id_stall;
    assign tr           = trap_valid;
    assign misalign     = br & ~tr & is_misaligned(pc_branch[1:0]);
    assign redirect_pc  = tr ? {trap_pc[31:2], 2'b00} : pc_branch;
    assign accept       = (state_q == FETCH_REQ) & imem_ready;
    assign waiting      = (state_q == FETCH_REQ) & ~imem_ready;
    assign stalled_full = id_valid_q & id_stall;

    // Trap handlers are always word aligned; the low bits are deliberately dropped.
    assign unused_trap_lsb = ^trap_pc[1:0];

    elbeth_fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .flush     (skid_flush),
        .load_data (imem_rdata),
        .load_pc   (pc_q),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    // Next-state, redirect handling and IF/ID / skid routing.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        kill_d       = kill_q;
        halt_pend_d  = halt_pend_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        misaligned_d = 1'b0;
        xcpt_d       = xcpt_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_flush   = 1'b0;

        if (tr || br) begin
            id_valid_d = 1'b0;
            skid_flush = 1'b1;
            if (misalign) begin
                misaligned_d = 1'b1;
                xcpt_d       = pc_branch;
            end
            if (waiting) begin
                // imem_addr must stay put until the abandoned response returns.
                kill_d      = 1'b1;
                target_d    = redirect_pc;
                halt_pend_d = misalign;
            end else begin
                kill_d      = 1'b0;
                halt_pend_d = 1'b0;
                if (misalign) begin
                    state_d = FETCH_HALT;
                end else begin
                    pc_d    = redirect_pc;
                    state_d = FETCH_REQ;
                end
            end
        end else if (kill_q) begin
            if (accept) begin
                kill_d      = 1'b0;
                halt_pend_d = 1'b0;
                if (halt_pend_q) begin
                    state_d = FETCH_HALT;
                end else begin
                    pc_d    = target_q;
                    state_d = FETCH_REQ;
                end
            end
        end else if (state_q != FETCH_HALT) begin
            if (accept) begin
                pc_d = pc_q + FETCH_STEP;
                if (!stalled_full) begin
                    id_valid_d = 1'b1;
                    id_instr_d = imem_rdata;
                    id_pc_d    = pc_q;
                end else begin
                    skid_load = 1'b1;
                end
            end else if (skid_valid && !stalled_full) begin
                id_valid_d = 1'b1;
                id_instr_d = skid_data;
                id_pc_d    = skid_pc;
                skid_drain = 1'b1;
            end else if (!id_stall) begin
                id_valid_d = 1'b0;
            end
            // A drained skid entry still costs one IDLE cycle before the next request.
            if (!waiting) begin
                state_d = (skid_valid || skid_load || (id_valid_d && id_stall))
                          ? FETCH_IDLE : FETCH_REQ;
            end
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_REQ;
            pc_q         <= RESET_PC;
            target_q     <= 32'h0;
            kill_q       <= 1'b0;
            halt_pend_q  <= 1'b0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'h0;
            id_pc_q      <= 32'h0;
            misaligned_q <= 1'b0;
            xcpt_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            kill_q       <= kill_d;
            halt_pend_q  <= halt_pend_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            misaligned_q <= misaligned_d;
            xcpt_q       <= xcpt_d;
        end
    end

    // Requests are abandoned immediately under reset.
    assign imem_valid       = (state_q == FETCH_REQ) & ~rst;
    assign imem_addr        = pc_q;
    assign id_valid         = id_valid_q;
    assign id_instruction   = id_instr_q;
    assign id_pc            = id_pc_q;
    assign fetch_misaligned = misaligned_q;
    assign xcpt_addr        = xcpt_q;

endmodule
